// File: rtl/gcbp_pkg.sv
// -----------------------------------------------------------------------------
// gcbp_pkg
// Constants and types shared by the GCBP sub-image generator/writer path and
// the sub-image reader. The BRAM address layout is {bank, subimage, line}:
// two frame banks (previous/current), four horizontal sub-images per frame
// and 128 lines per sub-image, one 128-bit gray-code bit-plane line per word.
// -----------------------------------------------------------------------------
package gcbp_pkg;

    localparam int BRAM_DATA_WIDTH      = 128;
    localparam int C_NUM_HORI_SUBIMAGES = 4;
    localparam int C_LINES_PER_SUBIMAGE = 128;
    localparam int C_LINE_CNT_BITS      = 7;

    // Address field widths; together they form the BRAM word address.
    localparam int C_BANK_BITS       = 1;
    localparam int C_SUBIMAGE_BITS   = 2;
    localparam int C_BRAM_ADDR_WIDTH = C_BANK_BITS + C_SUBIMAGE_BITS + C_LINE_CNT_BITS;

    // Reader control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } reader_state_t;

    // Build a BRAM word address from its three fields.
    function automatic logic [C_BRAM_ADDR_WIDTH-1:0] make_bram_addr(
        input logic [C_BANK_BITS-1:0]     bank,
        input logic [C_SUBIMAGE_BITS-1:0] subimage,
        input logic [C_LINE_CNT_BITS-1:0] line
    );
        return {bank, subimage, line};
    endfunction

endpackage

// File: rtl/gcbp_line_fifo.sv
// -----------------------------------------------------------------------------
// gcbp_line_fifo
// Two-entry FIFO for returned GCBP lines. Each entry is {idx, last, data}.
// The head entry is presented combinationally on o_data and does not change
// until it is popped, which gives the downstream handshake its stability.
// A flush empties the FIFO and takes priority over a same-cycle push.
//
// Ports:
//   i_clk     clock
//   i_resetn  asynchronous active-low reset
//   i_flush   discard all stored entries (synchronous)
//   i_push    write i_data (caller guarantees space)
//   i_data    entry to write
//   i_pop     consume the head entry (ignored when empty)
//   o_data    head entry
//   o_count   number of stored entries (0..2)
//   o_empty   no entry stored
// -----------------------------------------------------------------------------
module gcbp_line_fifo #(
    parameter int ENTRY_W = 136
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_data,
    output logic [1:0]         o_count,
    output logic               o_empty
);

    localparam int DEPTH = 2;

    logic [ENTRY_W-1:0] slot_reg [DEPTH];
    logic [DEPTH-1:0]   slot_wr;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               pop_ok;
    logic               push_ok;

    assign o_empty = (count_reg == 2'd0);
    assign pop_ok  = i_pop & ~o_empty;
    // A full FIFO can still take a push when its head leaves in the same cycle.
    assign push_ok = i_push & ((count_reg != 2'd2) | pop_ok);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_wr
            assign slot_wr[gi] = push_ok & ~i_flush & (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (i_flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_wr[i]) begin
                    slot_reg[i] <= i_data;
                end
            end
            count_reg <= count_next;
            if (i_flush) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop_ok) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
            end
        end
    end

    assign o_data  = slot_reg[rd_ptr_reg];
    assign o_count = count_reg;

endmodule

// File: rtl/gcbp_subimage_reader.sv
// -----------------------------------------------------------------------------
// gcbp_subimage_reader
// Streams one stored GCBP sub-image (128 lines of 128 bits) out of the
// sub-image BRAM to a valid/ready consumer. Reads are issued only while the
// FIFO plus the single in-flight read leave room, so a stalled consumer
// simply stops issue after two outstanding lines and nothing is lost.
//
// Ports:
//   i_clk, i_resetn      clock, asynchronous active-low reset
//   i_start              request (accepted in S_IDLE only)
//   i_bank               frame bank, sampled with an accepted i_start
//   i_subimage_sel       sub-image 0..3, sampled with an accepted i_start
//   i_abort              synchronous cancel, no o_done
//   o_busy               transfer in progress
//   o_done               one-cycle pulse after the last line handshake
//   o_bram_en            BRAM read enable
//   o_bram_addr          {bank, subimage, line}
//   i_bram_data          read data, one cycle after o_bram_en
//   o_line               line data, bit 127 = leftmost pixel
//   o_line_valid         o_line holds an unconsumed line
//   i_line_ready         consumer accepts the line
//   o_line_idx           line number of o_line
//   o_line_last          o_line is the last line of the sub-image
// -----------------------------------------------------------------------------
module gcbp_subimage_reader #(
    parameter int BRAM_DATA_WIDTH      = 128,
    parameter int C_LINES_PER_SUBIMAGE = 128,
    parameter int C_LINE_CNT_BITS      = 7,
    parameter int C_BRAM_ADDR_WIDTH    = 10
) (
    input  logic                         i_clk,
    input  logic                         i_resetn,
    input  logic                         i_start,
    input  logic                         i_bank,
    input  logic [1:0]                   i_subimage_sel,
    input  logic                         i_abort,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_bram_en,
    output logic [C_BRAM_ADDR_WIDTH-1:0] o_bram_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]   i_bram_data,
    output logic [BRAM_DATA_WIDTH-1:0]   o_line,
    output logic                         o_line_valid,
    input  logic                         i_line_ready,
    output logic [C_LINE_CNT_BITS-1:0]   o_line_idx,
    output logic                         o_line_last
);

    import gcbp_pkg::*;

    localparam int ENTRY_W = C_LINE_CNT_BITS + 1 + BRAM_DATA_WIDTH;
    localparam logic [C_LINE_CNT_BITS-1:0] LAST_LINE = C_LINE_CNT_BITS'(C_LINES_PER_SUBIMAGE - 1);

    reader_state_t              state_reg;
    reader_state_t              state_next;
    logic                       bank_reg;
    logic                       bank_next;
    logic [1:0]                 sub_reg;
    logic [1:0]                 sub_next;
    logic [C_LINE_CNT_BITS-1:0] issue_cnt_reg;
    logic [C_LINE_CNT_BITS-1:0] issue_cnt_next;
    logic                       done_reg;
    logic                       done_next;
    logic                       bram_en;

    // Tracks the one read whose data arrives on i_bram_data this cycle.
    logic                       inflight_reg;
    logic [C_LINE_CNT_BITS-1:0] inflight_idx_reg;

    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head_entry;
    logic [1:0]                 fifo_count;
    logic                       fifo_empty;
    logic                       pop;
    logic                       head_last;
    logic [2:0]                 occupancy;

    assign o_line_valid = ~fifo_empty;
    assign pop          = o_line_valid & i_line_ready;
    assign head_last    = head_entry[BRAM_DATA_WIDTH];

    // Lines that will be held after this cycle without a new issue. The pop
    // term is what lets issue resume in the same cycle ready rises.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

    always_comb begin
        state_next     = state_reg;
        bank_next      = bank_reg;
        sub_next       = sub_reg;
        issue_cnt_next = issue_cnt_reg;
        bram_en        = 1'b0;
        done_next      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next     = S_READ;
                    bank_next      = i_bank;
                    sub_next       = i_subimage_sel;
                    issue_cnt_next = '0;
                end
            end
            S_READ: begin
                if (occupancy < 3'd2) begin
                    bram_en = 1'b1;
                    // The counter parks on the last line instead of wrapping.
                    if (issue_cnt_reg == LAST_LINE) begin
                        state_next = S_DRAIN;
                    end else begin
                        issue_cnt_next = issue_cnt_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Cancel overrides everything, including a same-cycle start request.
        if (i_abort) begin
            state_next = S_IDLE;
            bank_next  = bank_reg;
            sub_next   = sub_reg;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_reg        <= S_IDLE;
            bank_reg         <= 1'b0;
            sub_reg          <= 2'd0;
            issue_cnt_reg    <= '0;
            done_reg         <= 1'b0;
            inflight_reg     <= 1'b0;
            inflight_idx_reg <= '0;
        end else begin
            state_reg        <= state_next;
            bank_reg         <= bank_next;
            sub_reg          <= sub_next;
            issue_cnt_reg    <= issue_cnt_next;
            done_reg         <= done_next;
            inflight_reg     <= bram_en & ~i_abort;
            inflight_idx_reg <= issue_cnt_reg;
        end
    end

    assign push_entry = {inflight_idx_reg, (inflight_idx_reg == LAST_LINE), i_bram_data};

    // A flush on abort also drops a return that lands in the abort cycle.
    gcbp_line_fifo #(
        .ENTRY_W (ENTRY_W)
    ) u_line_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_flush  (i_abort),
        .i_push   (inflight_reg),
        .i_data   (push_entry),
        .i_pop    (pop),
        .o_data   (head_entry),
        .o_count  (fifo_count),
        .o_empty  (fifo_empty)
    );

    assign o_busy      = (state_reg != S_IDLE);
    assign o_done      = done_reg;
    assign o_bram_en   = bram_en;
    assign o_bram_addr = make_bram_addr(bank_reg, sub_reg, issue_cnt_reg);
    assign o_line      = head_entry[BRAM_DATA_WIDTH-1:0];
    assign o_line_idx  = head_entry[ENTRY_W-1 -: C_LINE_CNT_BITS];
    assign o_line_last = head_last;

endmodule

// File: tb/tb_gcbp_subimage_reader.sv
// -----------------------------------------------------------------------------
// tb_gcbp_subimage_reader
// Directed bench for the GCBP sub-image reader with a behavioural BRAM whose
// words are a known function of their address.
// -----------------------------------------------------------------------------
module tb_gcbp_subimage_reader;

    logic         i_clk;
    logic         i_resetn;
    logic         i_start;
    logic         i_bank;
    logic [1:0]   i_subimage_sel;
    logic         i_abort;
    logic         o_busy;
    logic         o_done;
    logic         o_bram_en;
    logic [9:0]   o_bram_addr;
    logic [127:0] i_bram_data;
    logic [127:0] o_line;
    logic         o_line_valid;
    logic         i_line_ready;
    logic [6:0]   o_line_idx;
    logic         o_line_last;

    int n_cmp;
    int n_err;

    gcbp_subimage_reader dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_start        (i_start),
        .i_bank         (i_bank),
        .i_subimage_sel (i_subimage_sel),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_bram_en      (o_bram_en),
        .o_bram_addr    (o_bram_addr),
        .i_bram_data    (i_bram_data),
        .o_line         (o_line),
        .o_line_valid   (o_line_valid),
        .i_line_ready   (i_line_ready),
        .o_line_idx     (o_line_idx),
        .o_line_last    (o_line_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Known word content per address.
    function automatic logic [127:0] pat(input logic [9:0] a);
        return {a, 6'h15, ~a, 6'h2A, (32'hC0DE0000 | {22'd0, a}),
                (64'h0123_4567_89AB_CDEF ^ {54'd0, a})};
    endfunction

    logic [127:0] bram_mem [1024];
    always @(posedge i_clk) begin
        if (o_bram_en) begin
            i_bram_data <= bram_mem[o_bram_addr];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  128'(o_busy), 128'd0);
        chk({tag, "_done"},  128'(o_done), 128'd0);
        chk({tag, "_en"},    128'(o_bram_en), 128'd0);
        chk({tag, "_addr"},  128'(o_bram_addr), 128'd0);
        chk({tag, "_valid"}, 128'(o_line_valid), 128'd0);
        chk({tag, "_line"},  o_line, 128'd0);
        chk({tag, "_idx"},   128'(o_line_idx), 128'd0);
        chk({tag, "_last"},  128'(o_line_last), 128'd0);
    endtask

    // One full transfer. Called just after a negedge while the DUT is idle
    // (or in its o_done cycle); i_start is raised in the current cycle.
    task automatic run_xfer(input logic bank, input logic [1:0] sub, input logic [9:0] base,
                            input int ready_pct, input int poke_at, input int exp_done);
        int           c;
        int           exp_idx;
        int           issued;
        int           accepted;
        bit           finished;
        bit           prev_stall;
        logic [127:0] prev_line;
        logic [6:0]   prev_idx;
        chk("idle_before_start", 128'(o_busy), 128'd0);
        i_start        = 1'b1;
        i_bank         = bank;
        i_subimage_sel = sub;
        i_abort        = 1'b0;
        c = 0; exp_idx = 0; issued = 0; accepted = 0;
        finished = 1'b0; prev_stall = 1'b0; prev_line = '0; prev_idx = '0;
        while (!finished && c < 3000) begin
            @(negedge i_clk);
            c++;
            if (c == poke_at) begin
                i_start        = 1'b1;
                i_bank         = ~bank;
                i_subimage_sel = sub ^ 2'b01;
            end else begin
                i_start        = 1'b0;
                i_bank         = bank;
                i_subimage_sel = sub;
            end
            i_line_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (c == 1) chk("busy_after_start", 128'(o_busy), 128'd1);
            if (ready_pct == 100 && c == 3) chk("first_valid_T3", 128'(o_line_valid), 128'd1);
            if (prev_stall) begin
                chk("stall_valid", 128'(o_line_valid), 128'd1);
                chk("stall_line",  o_line, prev_line);
                chk("stall_idx",   128'(o_line_idx), 128'(prev_idx));
            end
            if (o_bram_en) begin
                chk("issue_addr", 128'(o_bram_addr), 128'(base + 10'(issued)));
                issued++;
            end else if (ready_pct == 100 && c <= 128) begin
                chk("issue_gap", 128'(o_bram_en), 128'd1);
            end
            if (o_line_valid && i_line_ready) begin
                chk("line_idx",  128'(o_line_idx), 128'(exp_idx));
                chk("line_data", o_line, pat(base + 10'(exp_idx)));
                chk("line_last", 128'(o_line_last), 128'(exp_idx == 127));
                exp_idx++;
                accepted++;
            end
            chk("outstanding_le2", 128'(issued - accepted <= 2), 128'd1);
            prev_stall = o_line_valid & ~i_line_ready;
            prev_line  = o_line;
            prev_idx   = o_line_idx;
            if (o_done) begin
                finished = 1'b1;
                chk("lines_at_done", 128'(exp_idx), 128'd128);
                chk("busy_at_done",  128'(o_busy), 128'd0);
                if (exp_done >= 0) chk("done_cycle", 128'(c), 128'(exp_done));
            end
        end
        if (!finished) chk("xfer_timeout", 128'd1, 128'd0);
        i_start = 1'b0;
        $display("xfer bank=%0d sub=%0d ready=%0d%% poke=%0d lines=%0d cycles=%0d",
                 bank, sub, ready_pct, poke_at, exp_idx, c);
    endtask

    typedef struct {
        logic       bank;
        logic [1:0] sub;
        int         ready_pct;
        int         poke_at;
        logic [9:0] exp_base;
        int         exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int a = 0; a < 1024; a++) bram_mem[a] = pat(10'(a));

        // Expected base = {bank, sub, 7'd0}; done at T+131 with ready held.
        vecs[0] = '{1'b1, 2'd2, 100, -1, 10'h300, 131};
        vecs[1] = '{1'b0, 2'd3, 100, -1, 10'h180, 131};
        vecs[2] = '{1'b1, 2'd0,  30, -1, 10'h200,  -1};
        vecs[3] = '{1'b0, 2'd1,  60, -1, 10'h080,  -1};
        vecs[4] = '{1'b1, 2'd1, 100, 12, 10'h280, 131};
        vecs[5] = '{1'b0, 2'd2, 100, -1, 10'h100, 131};

        i_resetn = 1'b0; i_start = 1'b0; i_bank = 1'b0; i_subimage_sel = 2'd0;
        i_abort = 1'b0; i_line_ready = 1'b0;
        #2;
        chk_reset_outputs("por");
        repeat (3) @(negedge i_clk);
        i_resetn = 1'b1;
        @(negedge i_clk);
        #1;

        // Consecutive entries start in the previous entry's o_done cycle.
        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].bank, vecs[v].sub, vecs[v].exp_base,
                     vecs[v].ready_pct, vecs[v].poke_at, vecs[v].exp_done);
        end

        // Abort while line 60 is stalled at the output.
        begin
            bit hit;
            hit = 1'b0;
            @(negedge i_clk); #1;
            i_start = 1'b1; i_bank = 1'b0; i_subimage_sel = 2'd1; i_line_ready = 1'b1;
            for (int k = 0; k < 300 && !hit; k++) begin
                @(negedge i_clk);
                i_start = 1'b0;
                #1;
                if (o_line_valid && o_line_idx == 7'd60) begin
                    i_line_ready = 1'b0;
                    i_abort      = 1'b1;
                    hit          = 1'b1;
                end
            end
            chk("abort_reached_line60", 128'(hit), 128'd1);
            @(negedge i_clk);
            i_abort = 1'b0;
            #1;
            chk("abort_busy",  128'(o_busy), 128'd0);
            chk("abort_valid", 128'(o_line_valid), 128'd0);
            chk("abort_done",  128'(o_done), 128'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge i_clk); #1;
                chk("post_abort_done",  128'(o_done), 128'd0);
                chk("post_abort_valid", 128'(o_line_valid), 128'd0);
            end
            $display("xfer abort bank=0 sub=1 at line 60");
            run_xfer(1'b0, 2'd0, 10'h000, 100, -1, 131);
        end

        // Abort and start together in idle: request dropped.
        @(negedge i_clk);
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_abort = 1'b0;
        #1;
        chk("abort_beats_start", 128'(o_busy), 128'd0);
        $display("xfer start+abort in idle dropped");

        // Asynchronous reset in the middle of a transfer.
        @(negedge i_clk); #1;
        i_start = 1'b1; i_bank = 1'b1; i_subimage_sel = 2'd3; i_line_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        #2;
        chk("pre_reset_busy", 128'(o_busy), 128'd1);
        i_resetn = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge i_clk);
        i_resetn = 1'b1;
        #1;
        $display("xfer async reset mid-transfer");
        run_xfer(1'b1, 2'd3, 10'h380, 100, -1, 131);

        repeat (3) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
